alu_share_ctrl: RTL
===================

ALU_SHARE_CTRL -- requirements
Module: alu_share_ctrl

Interface
REQ-001 Parameter ALU_LAT, default 1, meaning clock cycles from alu_in1/alu_in2/alu_select stable to alu_result valid; legal range 1..4.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0, req1  input  1 each  operation request from requester 0 / 1.
REQ-005 op0, op1  input  3 each  ALU select code: 000 ADD, 001 SUB, 010 IDEN, 011 LS, 100 RS, 101 AND, 110 NOT, 111 OR.
REQ-006 a0, b0, a1, b1  input  8 each  operands for requester 0 / 1.
REQ-007 gnt0, gnt1  output  1 each  one-cycle pulse: request accepted, operands captured.
REQ-008 done0, done1  output  1 each  one-cycle pulse: result valid for that requester.
REQ-009 result  output  8  last captured ALU result.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 alu_in1, alu_in2  output  8 each  operands driven to the shared ALU.
REQ-012 alu_select  output  3  op code driven to the shared ALU.
REQ-013 alu_result  input  8  result returned by the shared ALU.

Function
REQ-014 FSM SHALL have states IDLE, EXEC, DONE; IDLE -> EXEC on accept, EXEC -> DONE after ALU_LAT cycles, DONE -> IDLE unconditionally after one cycle.
REQ-015 In IDLE, a clock edge with req0 or req1 high SHALL accept exactly one request: the sole requester, or on tie the requester not granted last (round-robin pointer).
REQ-016 On accept, the winner's op/a/b SHALL be registered into alu_select/alu_in1/alu_in2, the winner's gnt SHALL be high for exactly the following cycle, and the pointer SHALL update to the winner.
REQ-017 alu_in1/alu_in2/alu_select SHALL hold their values through EXEC and DONE and until the next accept.
REQ-018 EXEC SHALL last exactly ALU_LAT cycles (down-counter); on the edge leaving EXEC, result SHALL capture alu_result.
REQ-019 In DONE, the done bit of the granted requester SHALL be high for exactly that one cycle; the other done bit SHALL stay low.
REQ-020 Latency: accept edge at cycle 0 -> done pulse in cycle ALU_LAT+1; minimum spacing between accepts is ALU_LAT+2 cycles.
REQ-021 req/op/a/b SHALL be ignored in EXEC and DONE; a req still high on return to IDLE SHALL be treated as a new request.
REQ-022 gnt0 and gnt1 SHALL never be high simultaneously; likewise done0 and done1.
REQ-023 result SHALL hold its value until the next capture.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, counter 0, pointer to requester 1 (requester 0 wins first tie), and all outputs (gnt*, done*, busy, result, alu_in1, alu_in2, alu_select) to 0.
REQ-025 Reset during EXEC or DONE SHALL abort the operation with no done pulse after release.

Configuration
REQ-026 With ALU_SHARE_CNT_EN defined, outputs op_cnt0 and op_cnt1 (8 bits each, reset 0) SHALL increment on each done0/done1 pulse respectively, wrapping 255 -> 0.
REQ-027 Without ALU_SHARE_CNT_EN, op_cnt0/op_cnt1 and their logic SHALL be absent; all other behaviour identical.

Verification
REQ-028 ALU_LAT=1, req0 only, op0=000, a0=204, b0=51 -> gnt0 cycle 1, done0 cycle 2, result=255, done1 never high.
REQ-029 req0 and req1 both high from reset, op0=001 a0=170 b0=85, op1=111 a1=85 b1=170 -> gnt0 first, done0 with result 85; then gnt1, done1 with result 255.
REQ-030 Both reqs held high for 4 ops -> grant order 0,1,0,1; accepts spaced exactly ALU_LAT+2 cycles; busy low only one cycle between ops.
REQ-031 ALU_LAT=3, req1 op1=011 a1=85 -> done1 exactly 4 cycles after accept edge, result=170.
REQ-032 rst_n pulsed low during EXEC -> all outputs 0 at once, no done pulse after release, next req0 gets first grant.
REQ-033 ALU_SHARE_CNT_EN defined, 257 req0 ops -> op_cnt0=1, op_cnt1=0; undefined build compiles without op_cnt ports.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// Two-requester arbiter sharing one external ALU: round-robin accept, fixed-latency execute, done pulse.
// Optional per-requester completion counters op_cnt0/op_cnt1 when ALU_SHARE_CNT_EN is defined.
module alu_share_ctrl #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [2:0] op0,
  input  logic [2:0] op1,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] result,
  output logic       busy,
  output logic [7:0] alu_in1,
  output logic [7:0] alu_in2,
  output logic [2:0] alu_select,
  input  logic [7:0] alu_result
`ifdef ALU_SHARE_CNT_EN
  ,
  output logic [7:0] op_cnt0,
  output logic [7:0] op_cnt1
`endif
);

  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic   [CW-1:0] r_cnt;
  logic            r_last;
  logic            r_gnt0;
  logic            r_gnt1;
  logic            r_done0;
  logic            r_done1;
  logic   [7:0]    r_result;
  logic   [7:0]    r_alu_in1;
  logic   [7:0]    r_alu_in2;
  logic   [2:0]    r_alu_select;
  logic            w_accept;
  logic            w_win;
  logic            w_exec_end;

  assign w_accept   = (r_state == IDLE) && (req0 || req1);
  // Tie goes to whoever was not granted last; r_last doubles as the current owner.
  assign w_win      = (req0 && req1) ? ~r_last : req1;
  assign w_exec_end = (r_state == EXEC) && (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = EXEC;
      EXEC:    if (r_cnt == '0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_last       <= 1'b1;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_result     <= '0;
      r_alu_in1    <= '0;
      r_alu_in2    <= '0;
      r_alu_select <= '0;
    end else begin
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      if (w_accept) begin
        r_gnt0       <= ~w_win;
        r_gnt1       <= w_win;
        r_last       <= w_win;
        r_alu_select <= w_win ? op1 : op0;
        r_alu_in1    <= w_win ? a1 : a0;
        r_alu_in2    <= w_win ? b1 : b0;
        r_cnt        <= CW'(ALU_LAT - 1);
      end else if ((r_state == EXEC) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 2'd1;
      end
      if (w_exec_end) begin
        r_result <= alu_result;
        r_done0  <= ~r_last;
        r_done1  <= r_last;
      end
    end
  end

  assign gnt0       = r_gnt0;
  assign gnt1       = r_gnt1;
  assign done0      = r_done0;
  assign done1      = r_done1;
  assign result     = r_result;
  assign busy       = (r_state != IDLE);
  assign alu_in1    = r_alu_in1;
  assign alu_in2    = r_alu_in2;
  assign alu_select = r_alu_select;

`ifdef ALU_SHARE_CNT_EN
  logic [7:0] r_op_cnt0;
  logic [7:0] r_op_cnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_cnt0 <= '0;
      r_op_cnt1 <= '0;
    end else begin
      if (r_done0) r_op_cnt0 <= r_op_cnt0 + 8'd1;
      if (r_done1) r_op_cnt1 <= r_op_cnt1 + 8'd1;
    end
  end

  assign op_cnt0 = r_op_cnt0;
  assign op_cnt1 = r_op_cnt1;
`endif

endmodule
